// File: rtl/i2c_if.sv
// Two-wire bus: scl from the controller, sda as a wired-AND with pull-up.
// Each side contributes a pull-low enable; releasing the enable leaves sda to the pull-up.
interface i2c_if;
    logic scl;
    logic sda_tgt_low;
    logic sda_ctl_low;
    logic sda;

    assign sda = ~(sda_tgt_low | sda_ctl_low);

    modport target (input scl, input sda, output sda_tgt_low);
    modport controller (output scl, output sda_ctl_low, input sda);
endinterface

// File: rtl/i2c_target.sv
// I2C target: 7-bit address match, byte writes to rx_data, byte reads from tx_data.
// scl/sda are double-synchronised; all bus changes happen only while scl is low.
module i2c_target #(
    parameter logic [6:0] ADDR = 7'h18
) (
    input  logic       clk,
    input  logic       rst,
    i2c_if.target      i2c,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_nak,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_WR_DATA,
        ST_WR_ACK, ST_RD_DATA, ST_RD_ACK, ST_IGNORE
    } state_t;

    state_t      state_q, state_d;
    logic        scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d, scl_prev_q, scl_prev_d;
    logic        sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d, sda_prev_q, sda_prev_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  shreg_q, shreg_d;
    logic        rw_q, rw_d;
    logic        ack_seen_q, ack_seen_d;
    logic        sda_low_q, sda_low_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        tx_req_q, tx_req_d;
    logic        busy_q, busy_d;
    logic        scl_rise, scl_fall, start_det, stop_det;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // Idle-bus values so release of sda during reset is not seen as an edge
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            rw_q       <= 1'b0;
            ack_seen_q <= 1'b0;
            sda_low_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            scl_s1_q   <= scl_s1_d;
            scl_s2_q   <= scl_s2_d;
            scl_prev_q <= scl_prev_d;
            sda_s1_q   <= sda_s1_d;
            sda_s2_q   <= sda_s2_d;
            sda_prev_q <= sda_prev_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            rw_q       <= rw_d;
            ack_seen_q <= ack_seen_d;
            sda_low_q  <= sda_low_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        scl_s1_d   = i2c.scl;
        scl_s2_d   = scl_s1_q;
        scl_prev_d = scl_s2_q;
        sda_s1_d   = i2c.sda;
        sda_s2_d   = sda_s1_q;
        sda_prev_d = sda_s2_q;
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        rw_d       = rw_q;
        ack_seen_d = ack_seen_q;
        sda_low_d  = sda_low_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        busy_d     = busy_q;

        scl_rise  = scl_s2_q & ~scl_prev_q;
        scl_fall  = ~scl_s2_q & scl_prev_q;
        start_det = scl_s2_q & scl_prev_q & sda_prev_q & ~sda_s2_q;
        stop_det  = scl_s2_q & scl_prev_q & ~sda_prev_q & sda_s2_q;

        if (start_det) begin
            state_d    = ST_ADDR;
            bit_cnt_d  = '0;
            sda_low_d  = 1'b0;
            busy_d     = 1'b0;
            ack_seen_d = 1'b0;
        end else if (stop_det) begin
            state_d   = ST_IDLE;
            sda_low_d = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: if (scl_rise) begin
                    shreg_d   = {shreg_q[5:0], sda_s2_q};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (shreg_q == ADDR) begin
                            busy_d  = 1'b1;
                            rw_d    = sda_s2_q;
                            state_d = ST_ADDR_ACK;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                // First falling edge starts the ACK drive, the second ends the slot
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_low_q) begin
                            sda_low_d = 1'b1;
                        end else if (rw_q) begin
                            bit_cnt_d = '0;
                            shreg_d   = tx_data[6:0];
                            sda_low_d = ~tx_data[7];
                            state_d   = ST_RD_DATA;
                        end else begin
                            bit_cnt_d = '0;
                            sda_low_d = 1'b0;
                            state_d   = ST_WR_DATA;
                        end
                    end else if (scl_rise && sda_low_q && rw_q) begin
                        tx_req_d = 1'b1;
                    end
                end
                ST_WR_DATA: if (scl_rise) begin
                    shreg_d   = {shreg_q[5:0], sda_s2_q};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d  = {shreg_q, sda_s2_q};
                        rx_valid_d = 1'b1;
                        state_d    = rx_nak ? ST_IGNORE : ST_WR_ACK;
                    end
                end
                ST_WR_ACK: if (scl_fall) begin
                    if (!sda_low_q) begin
                        sda_low_d = 1'b1;
                    end else begin
                        sda_low_d = 1'b0;
                        state_d   = ST_WR_DATA;
                    end
                end
                // bit_cnt wraps to 0 on the 8th rise; the following fall ends the byte
                ST_RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 3'd0) begin
                            sda_low_d  = 1'b0;
                            ack_seen_d = 1'b0;
                            state_d    = ST_RD_ACK;
                        end else begin
                            sda_low_d = ~shreg_q[6];
                            shreg_d   = {shreg_q[5:0], 1'b0};
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s2_q) begin
                            ack_seen_d = 1'b1;
                            tx_req_d   = 1'b1;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end else if (scl_fall && ack_seen_q) begin
                        ack_seen_d = 1'b0;
                        bit_cnt_d  = '0;
                        shreg_d    = tx_data[6:0];
                        sda_low_d  = ~tx_data[7];
                        state_d    = ST_RD_DATA;
                    end
                end
                ST_IDLE, ST_IGNORE: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign i2c.sda_tgt_low = sda_low_q;
    assign rx_data         = rx_data_q;
    assign rx_valid        = rx_valid_q;
    assign tx_req          = tx_req_q;
    assign busy            = busy_q;
endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bus-level controller stimulus, transaction-level reference
// model feeding expectation queues, and a monitor that scores DUT outputs as they appear.
module tb_i2c_target;
    localparam logic [6:0] TGT = 7'h18;
    localparam int Q = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_nak = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_req;
    logic       busy;

    i2c_if bus();

    i2c_target #(.ADDR(TGT)) dut (
        .clk(clk), .rst(rst), .i2c(bus),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_nak(rx_nak),
        .tx_data(tx_data), .tx_req(tx_req), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    val;
    } item_t;

    item_t      exp_bus[$];
    item_t      got_bus[$];
    logic [7:0] exp_rx[$];
    logic [7:0] tx_src[$];
    logic [7:0] wr_data[$];
    bit         wr_nak[$];
    logic [7:0] rd_data[$];

    int n_checks = 0, n_errors = 0;
    int n_rx = 0, n_txreq = 0, busy_hi = 0, busy_falls = 0, drv_cnt = 0, drv_while_high = 0;
    logic busy_prev = 1'b0, drv_prev = 1'b0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic push_exp(input string name, input int val);
        item_t it;
        it.name = name;
        it.val  = val;
        exp_bus.push_back(it);
    endtask

    task automatic push_got(input string name, input int val);
        item_t it;
        it.name = name;
        it.val  = val;
        got_bus.push_back(it);
    endtask

    // Monitor / scoreboard / tx_data responder
    initial begin
        item_t e, g;
        forever begin
            @(negedge clk);
            if (rx_valid) begin
                n_rx++;
                if (exp_rx.size() > 0) begin
                    check("rx_data", int'(rx_data), int'(exp_rx.pop_front()));
                end else begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rx_valid: got pulse with data 0x%0h, expected no pulse", rx_data);
                end
            end
            if (tx_req) begin
                n_txreq++;
                if (tx_src.size() > 0) tx_data = tx_src.pop_front();
                else                   tx_data = 8'($urandom);
            end
            while (got_bus.size() > 0) begin
                g = got_bus.pop_front();
                if (exp_bus.size() > 0) begin
                    e = exp_bus.pop_front();
                    check(e.name, g.val, e.val);
                end else begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL %s: got 0x%0h with no expectation queued", g.name, g.val);
                end
            end
            if (busy) busy_hi++;
            if (busy_prev && !busy) busy_falls++;
            busy_prev = busy;
            if (bus.sda_tgt_low) drv_cnt++;
            if (!drv_prev && bus.sda_tgt_low && bus.scl) drv_while_high++;
            drv_prev = bus.sda_tgt_low;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_q();
        #(Q);
    endtask

    task automatic send_bit(input bit b);
        wait_q(); bus.sda_ctl_low = ~b;
        wait_q(); bus.scl = 1'b1;
        wait_q(); wait_q(); bus.scl = 1'b0;
    endtask

    task automatic recv_bit(output bit v);
        wait_q(); bus.sda_ctl_low = 1'b0;
        wait_q(); bus.scl = 1'b1;
        wait_q(); v = bus.sda;
        wait_q(); bus.scl = 1'b0;
    endtask

    task automatic i2c_start();
        if (!bus.scl) begin
            wait_q(); bus.sda_ctl_low = 1'b0;
            wait_q(); bus.scl = 1'b1;
        end
        wait_q(); bus.sda_ctl_low = 1'b1;
        wait_q(); bus.scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_q(); bus.sda_ctl_low = 1'b1;
        wait_q(); bus.scl = 1'b1;
        wait_q(); bus.sda_ctl_low = 1'b0;
        wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, output bit ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        recv_bit(ack);
    endtask

    task automatic read_byte(input bit nak, output logic [7:0] v);
        bit bv;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(bv);
            v[i] = bv;
        end
        send_bit(nak);
    endtask

    // Reference model: a write is ACKed while the address matched and no byte was refused.
    task automatic xfer_write(input logic [7:0] abyte, input bit do_stop);
        bit matched, alive, ack;
        int rx0, tx0, bh0, exp_cnt;
        matched = (abyte[7:1] == TGT);
        rx0 = n_rx; tx0 = n_txreq; bh0 = busy_hi; exp_cnt = 0;
        i2c_start();
        push_exp("addr_ack", matched ? 0 : 1);
        write_byte(abyte, ack);
        push_got("addr_ack", int'(ack));
        alive = matched;
        foreach (wr_data[i]) begin
            rx_nak = wr_nak[i];
            if (alive) begin
                exp_rx.push_back(wr_data[i]);
                exp_cnt++;
            end
            push_exp("wr_ack", (alive && !wr_nak[i]) ? 0 : 1);
            alive = alive && !wr_nak[i];
            write_byte(wr_data[i], ack);
            push_got("wr_ack", int'(ack));
        end
        rx_nak = 1'b0;
        repeat (2) @(negedge clk);
        check("wr_rx_count", n_rx - rx0, exp_cnt);
        check("wr_txreq_count", n_txreq - tx0, 0);
        check("wr_busy", int'(busy), int'(matched));
        if (!matched) check("nomatch_busy_cycles", busy_hi - bh0, 0);
        if (do_stop) begin
            i2c_stop();
            repeat (2) @(negedge clk);
            check("stop_busy", int'(busy), 0);
            check("stop_sda", int'(bus.sda_tgt_low), 0);
        end
    endtask

    // Reference model: a matched read returns the supplied bytes in order, one tx_req each.
    task automatic xfer_read(input logic [7:0] abyte, input bit do_stop);
        bit matched, ack;
        int rx0, tx0, bf0, n;
        logic [7:0] v;
        matched = (abyte[7:1] == TGT);
        n = rd_data.size();
        rx0 = n_rx; tx0 = n_txreq;
        if (matched) foreach (rd_data[i]) tx_src.push_back(rd_data[i]);
        i2c_start();
        push_exp("addr_ack", matched ? 0 : 1);
        write_byte(abyte, ack);
        push_got("addr_ack", int'(ack));
        bf0 = busy_falls;
        for (int i = 0; i < n; i++) begin
            push_exp("rd_byte", matched ? int'(rd_data[i]) : 8'hFF);
            read_byte(i == n - 1, v);
            push_got("rd_byte", int'(v));
        end
        repeat (2) @(negedge clk);
        check("rd_txreq_count", n_txreq - tx0, matched ? n : 0);
        check("rd_rx_count", n_rx - rx0, 0);
        check("rd_nak_release", int'(bus.sda_tgt_low), 0);
        check("rd_busy", int'(busy), int'(matched));
        check("rd_busy_steady", busy_falls - bf0, 0);
        check("rd_tx_left", tx_src.size(), 0);
        tx_src.delete();
        if (do_stop) begin
            i2c_stop();
            repeat (2) @(negedge clk);
            check("stop_busy", int'(busy), 0);
        end
    endtask

    initial begin
        bit ack, bv;
        logic [7:0] v;
        int drv0, tx0;
        bus.scl = 1'b1;
        bus.sda_ctl_low = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rx_data", int'(rx_data), 0);
        check("reset_rx_valid", int'(rx_valid), 0);
        check("reset_tx_req", int'(tx_req), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_sda", int'(bus.sda_tgt_low), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Matching address byte without a preceding START is ignored
        wait_q(); bus.scl = 1'b0;
        push_exp("prestart_ack", 1);
        write_byte(8'h30, ack);
        push_got("prestart_ack", int'(ack));
        i2c_stop();

        wr_data = '{8'h12, 8'h32, 8'h99}; wr_nak = '{0, 0, 0};
        xfer_write(8'h30, 1'b1);

        rd_data = '{8'h00, 8'hFF, 8'hAC};
        xfer_read(8'h31, 1'b1);

        wr_data = '{8'h5A}; wr_nak = '{0};
        xfer_write(8'h34, 1'b1);

        wr_data = '{8'hAA, 8'h3C}; wr_nak = '{1, 0};
        xfer_write(8'h30, 1'b1);

        wr_data = '{8'h55}; wr_nak = '{0};
        xfer_write(8'h30, 1'b0);
        rd_data = '{8'hC3, 8'h0F};
        xfer_read(8'h31, 1'b1);

        // Reset in the middle of the 4th bit of a read of 0x00
        tx0 = n_txreq;
        tx_src.push_back(8'h00);
        i2c_start();
        push_exp("addr_ack", 0);
        write_byte(8'h31, ack);
        push_got("addr_ack", int'(ack));
        for (int i = 0; i < 3; i++) begin
            push_exp("rd_bit", 0);
            recv_bit(bv);
            push_got("rd_bit", int'(bv));
        end
        wait_q(); bus.sda_ctl_low = 1'b0;
        wait_q(); bus.scl = 1'b1;
        wait_q();
        check("pre_rst_drive", int'(bus.sda_tgt_low), 1);
        rst = 1'b1;
        #1;
        check("rst_sda_release", int'(bus.sda_tgt_low), 0);
        #9;
        rst = 1'b0;
        #(Q - 10);
        bus.scl = 1'b0;
        check("rst_rx_data", int'(rx_data), 0);
        check("rst_busy", int'(busy), 0);
        drv0 = drv_cnt;
        for (int i = 0; i < 4; i++) recv_bit(bv);
        send_bit(1'b0);
        push_exp("post_rst_byte", 8'hFF);
        read_byte(1'b1, v);
        push_got("post_rst_byte", int'(v));
        check("post_rst_drive", drv_cnt - drv0, 0);
        check("rst_txreq_count", n_txreq - tx0, 1);
        tx_src.delete();
        i2c_stop();
        wr_data = '{8'h7E}; wr_nak = '{0};
        xfer_write(8'h30, 1'b1);

        for (int t = 0; t < 10; t++) begin
            logic [6:0] a7;
            int n;
            a7 = ($urandom_range(0, 3) == 0) ? 7'($urandom) : TGT;
            n = $urandom_range(1, 4);
            if ($urandom_range(0, 1) == 0) begin
                wr_data.delete(); wr_nak.delete();
                for (int i = 0; i < n; i++) begin
                    wr_data.push_back(8'($urandom));
                    wr_nak.push_back($urandom_range(0, 4) == 0);
                end
                xfer_write({a7, 1'b0}, 1'b1);
            end else begin
                rd_data.delete();
                for (int i = 0; i < n; i++) rd_data.push_back(8'($urandom));
                xfer_read({a7, 1'b1}, 1'b1);
            end
        end

        repeat (5) @(negedge clk);
        check("exp_bus_left", exp_bus.size(), 0);
        check("exp_rx_left", exp_rx.size(), 0);
        check("drive_while_scl_high", drv_while_high, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
